// File: rtl/mealy_pkg.sv
// Shared types, symbol constants and next-state rule of the 4-state Mealy symbol code.
package mealy_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } state_t;

    localparam logic [2:0] SYM_A0      = 3'b111;
    localparam logic [2:0] SYM_A1      = 3'b101;
    localparam logic [2:0] SYM_B0      = 3'b001;
    localparam logic [2:0] SYM_B1      = 3'b011;
    localparam logic [2:0] SYM_C0      = 3'b000;
    localparam logic [2:0] SYM_C1      = 3'b100;
    localparam logic [2:0] SYM_D       = 3'b110;
    localparam logic [2:0] SYM_ILLEGAL = 3'b010;

    function automatic state_t next_state(input state_t st, input logic in_bit);
        case (st)
            ST_A:    return in_bit ? ST_C : ST_B;
            ST_B:    return in_bit ? ST_D : ST_A;
            ST_C:    return in_bit ? ST_A : ST_D;
            default: return ST_A;
        endcase
    endfunction

endpackage

// File: rtl/mealy_sym_tracker_if.sv
// Symbol-in / recovered-bit-out handshake bundle; master is the link side, slave the tracker.
interface mealy_sym_tracker_if;
    logic       sym_valid;
    logic [2:0] sym;
    logic       sym_ready;
    logic       bit_valid;
    logic       bit_ready;
    logic       bit_out;
    logic       bit_amb;
    logic       bit_err;

    modport master (
        output sym_valid, sym, bit_ready,
        input  sym_ready, bit_valid, bit_out, bit_amb, bit_err
    );

    modport slave (
        input  sym_valid, sym, bit_ready,
        output sym_ready, bit_valid, bit_out, bit_amb, bit_err
    );
endinterface

// File: rtl/mealy_sym_lookup.sv
// Purpose: classify a symbol against the tracked state and decode its owning state and bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle regardless of handshake.
module mealy_sym_lookup
    import mealy_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] sym,
    output logic       legal,
    output logic       dec_bit,
    output logic       amb,
    output state_t     implied_state,
    output logic       implied_valid
);

    // Every symbol except SYM_ILLEGAL has exactly one owner, so the decode needs only sym.
    always_comb begin
        implied_state = ST_A;
        implied_valid = 1'b1;
        dec_bit       = 1'b0;
        case (sym)
            SYM_A0:  begin implied_state = ST_A; dec_bit = 1'b0; end
            SYM_A1:  begin implied_state = ST_A; dec_bit = 1'b1; end
            SYM_B0:  begin implied_state = ST_B; dec_bit = 1'b0; end
            SYM_B1:  begin implied_state = ST_B; dec_bit = 1'b1; end
            SYM_C0:  begin implied_state = ST_C; dec_bit = 1'b0; end
            SYM_C1:  begin implied_state = ST_C; dec_bit = 1'b1; end
            SYM_D:   begin implied_state = ST_D; dec_bit = 1'b0; end
            default: implied_valid = 1'b0;
        endcase
    end

    assign amb   = implied_valid && (implied_state == ST_D);
    assign legal = implied_valid && (implied_state == state);

endmodule

// File: rtl/mealy_sym_tracker.sv
// Purpose: recover input bits from a Mealy symbol stream, flag ambiguous/illegal symbols, resync.
// Latency: one cycle, symbol accepted on edge N is presented after edge N.
// Backpressure: one-entry output register; sym_ready = !clr && (!bit_valid || bit_ready).
module mealy_sym_tracker
    import mealy_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    mealy_sym_tracker_if.slave  bus,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    sym_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    state_t           state_q, state_d;
    logic             legal, dec_bit, amb, implied_valid;
    state_t           implied_state;
    logic             accept;
    logic             bit_valid_q, bit_out_q, bit_amb_q, bit_err_q;
    logic             bit_out_d, bit_amb_d, bit_err_d;
    logic [CNT_W-1:0] sym_cnt_q, err_cnt_q;

    mealy_sym_lookup u_lookup (
        .state         (state_q),
        .sym           (bus.sym),
        .legal         (legal),
        .dec_bit       (dec_bit),
        .amb           (amb),
        .implied_state (implied_state),
        .implied_valid (implied_valid)
    );

    assign bus.sym_ready = !clr && (!bit_valid_q || bus.bit_ready);
    assign accept        = bus.sym_valid && bus.sym_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= ST_A;
        else if (clr) state_q <= ST_A;
        else          state_q <= state_d;
    end

    // A legal symbol's implied state equals the tracked state, so one rule covers decode and resync.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = implied_valid ? next_state(implied_state, dec_bit) : ST_A;
    end

    always_comb begin
        bit_out_d = legal && !amb && dec_bit;
        bit_amb_d = legal && amb;
        bit_err_d = !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_amb_q   <= 1'b0;
            bit_err_q   <= 1'b0;
        end else if (clr) begin
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_amb_q   <= 1'b0;
            bit_err_q   <= 1'b0;
        end else if (accept) begin
            bit_valid_q <= 1'b1;
            bit_out_q   <= bit_out_d;
            bit_amb_q   <= bit_amb_d;
            bit_err_q   <= bit_err_d;
        end else if (bus.bit_ready) begin
            bit_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (clr) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (accept) begin
            sym_cnt_q <= sym_cnt_q + CNT_W'(1);
            if (!legal && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_amb   = bit_amb_q;
    assign bus.bit_err   = bit_err_q;
    assign state_o       = state_q;
    assign sym_cnt       = sym_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mealy_sym_tracker.sv
// Scoreboard bench for mealy_sym_tracker: model pushes expected beats on accept, monitor pops on drain.
module tb_mealy_sym_tracker;

    typedef struct packed {
        logic       out;
        logic       amb;
        logic       err;
        logic [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] state_o;
    logic [7:0] sym_cnt, err_cnt;

    mealy_sym_tracker_if bus ();

    mealy_sym_tracker #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bus),
        .state_o (state_o),
        .sym_cnt (sym_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       q[$];
    logic [1:0] m_st = 2'd0;
    logic [7:0] m_sym_cnt = 8'd0;
    logic [7:0] m_err_cnt = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sender's code table: symbol emitted from state st for input b.
    function automatic logic [2:0] sym_of(input logic [1:0] st, input logic b);
        case (st)
            2'd0:    return b ? 3'b101 : 3'b111;
            2'd1:    return b ? 3'b011 : 3'b001;
            2'd2:    return b ? 3'b100 : 3'b000;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic [1:0] nxt_of(input logic [1:0] st, input logic b);
        case (st)
            2'd0:    return b ? 2'd2 : 2'd1;
            2'd1:    return b ? 2'd3 : 2'd0;
            2'd2:    return b ? 2'd0 : 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_accept(input logic [2:0] s);
        exp_t       e;
        logic       b;
        logic [1:0] nx;
        e = '0;
        if (sym_of(m_st, 1'b0) == s || sym_of(m_st, 1'b1) == s) begin
            b     = (m_st != 2'd3) && (sym_of(m_st, 1'b1) == s);
            e.amb = (m_st == 2'd3);
            e.out = b;
            m_st  = nxt_of(m_st, b);
        end else begin
            e.err = 1'b1;
            nx    = 2'd0;
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 2; j++)
                    if (sym_of(2'(k), 1'(j)) == s) nx = nxt_of(2'(k), 1'(j));
            m_st = nx;
            if (m_err_cnt != 8'hff) m_err_cnt = m_err_cnt + 8'd1;
        end
        e.st      = m_st;
        m_sym_cnt = m_sym_cnt + 8'd1;
        q.push_back(e);
    endtask

    task automatic model_reset();
        q.delete();
        m_st      = 2'd0;
        m_sym_cnt = 8'd0;
        m_err_cnt = 8'd0;
    endtask

    task automatic send(input logic [2:0] s);
        int guard;
        guard         = 0;
        bus.sym       = s;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        while (!bus.sym_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.sym_ready) chk("send_timeout", 32'(bus.sym_ready), 32'd1);
        else                model_accept(s);
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_sym_cnt"}, 32'(sym_cnt), 32'(m_sym_cnt));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err_cnt));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.bit_valid && bus.bit_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bit_out", 32'(bus.bit_out), 32'(e.out));
                chk("bit_amb", 32'(bus.bit_amb), 32'(e.amb));
                chk("bit_err", 32'(bus.bit_err), 32'(e.err));
                chk("state_o", 32'(state_o),     32'(e.st));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] s;
        logic [7:0] cnt0;
        bus.sym_valid = 1'b0;
        bus.sym       = 3'b000;
        bus.bit_ready = 1'b0;

        #1;
        chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("rst_bit_out",   32'(bus.bit_out),   32'd0);
        chk("rst_bit_amb",   32'(bus.bit_amb),   32'd0);
        chk("rst_bit_err",   32'(bus.bit_err),   32'd0);
        chk("rst_state",     32'(state_o),       32'd0);
        chk_counters("rst");
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_sym_ready", 32'(bus.sym_ready), 32'd1);

        // Basic decode walk A->B->D->A->C->D
        bus.bit_ready = 1'b1;
        send(3'b111);
        send(3'b011);
        send(3'b110);
        send(3'b101);
        send(3'b000);
        idle(2);
        chk("walk_sym_cnt", 32'(sym_cnt), 32'd5);
        chk("walk_err_cnt", 32'(err_cnt), 32'd0);
        chk("walk_state",   32'(state_o), 32'd3);
        chk("walk_drained", 32'(q.size()), 32'd0);

        // clr with a symbol presented: not accepted, everything back to A/0
        bus.sym       = 3'b111;
        bus.sym_valid = 1'b1;
        clr           = 1'b1;
        @(negedge clk);
        chk("clr_sym_ready", 32'(bus.sym_ready), 32'd0);
        @(posedge clk);
        #1;
        clr           = 1'b0;
        bus.sym_valid = 1'b0;
        model_reset();
        chk("clr_state",     32'(state_o),       32'd0);
        chk("clr_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk_counters("clr");

        // Illegal 001 from A resyncs through B with in=0 back to A
        send(3'b001);
        send(3'b111);
        idle(2);
        chk("illegal_state", 32'(state_o), 32'd1);
        chk("illegal_err_cnt", 32'(err_cnt), 32'd1);

        // Repeated 010: forces A, error counter saturates
        for (int i = 0; i < 300; i++) send(3'b010);
        idle(2);
        chk("sat_err_cnt", 32'(err_cnt), 32'hff);
        chk_counters("sat");

        // Backpressure then simultaneous drain and reload
        bus.bit_ready = 1'b0;
        send(sym_of(m_st, 1'b1));
        bus.sym       = sym_of(m_st, 1'b0);
        bus.sym_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_sym_ready", 32'(bus.sym_ready), 32'd0);
            chk("bp_bit_valid", 32'(bus.bit_valid), 32'd1);
            chk("bp_bit_out",   32'(bus.bit_out),   32'(q[0].out));
            chk("bp_state",     32'(state_o),       32'(m_st));
            chk_counters("bp");
        end
        @(posedge clk);
        #1;
        bus.bit_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.sym_ready), 32'd1);
        model_accept(bus.sym);
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        @(negedge clk);
        chk("bp_reload_valid", 32'(bus.bit_valid), 32'd1);
        idle(2);

        // 256 legal symbols: sym_cnt wraps back to its start value
        cnt0 = sym_cnt;
        for (int i = 0; i < 256; i++) send(sym_of(m_st, 1'($urandom_range(0, 1))));
        idle(2);
        chk("wrap_sym_cnt", 32'(sym_cnt), 32'(cnt0));
        chk_counters("wrap");

        // Async reset while a beat is pending
        bus.bit_ready = 1'b0;
        send(sym_of(m_st, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("arst_state",     32'(state_o),       32'd0);
        chk("arst_sym_cnt",   32'(sym_cnt),       32'd0);
        model_reset();
        bus.bit_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s = 3'b101;
        send(s);
        idle(2);
        chk("post_rst_state", 32'(state_o), 32'd2);
        chk_counters("post_rst");
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
